// File: rtl/gmem_stream_engine.sv
// Streams 4-word groups between global memory and rd/wr data streams.
// Define GMEM_STREAM_STATS_EN to add the stat_words transfer counter.
module gmem_stream_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_groups,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              done,
    output logic [ADDR_W-1:0] gm_address,
    output logic              gm_we,
    output logic [DATA_W-1:0] gm_wd1,
    output logic [DATA_W-1:0] gm_wd2,
    output logic [DATA_W-1:0] gm_wd3,
    output logic [DATA_W-1:0] gm_wd4,
    input  logic [DATA_W-1:0] gm_rd1,
    input  logic [DATA_W-1:0] gm_rd2,
    input  logic [DATA_W-1:0] gm_rd3,
    input  logic [DATA_W-1:0] gm_rd4
`ifdef GMEM_STREAM_STATS_EN
    ,
    output logic [15:0]       stat_words
`endif
);

    typedef enum logic [2:0] {
        IDLE, RD_LATCH, RD_SEND, WR_COLLECT, WR_COMMIT, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        left;
    logic [1:0]        idx;
    logic [DATA_W-1:0] wbuf [4];

    logic              rd_hs;
    logic              wr_hs;
    logic [ADDR_W-1:0] next_addr;

    assign rd_hs     = rd_valid && rd_ready;
    assign wr_hs     = wr_valid && wr_ready;
    assign next_addr = addr + ADDR_W'(4);

    assign rd_data = wbuf[idx];
    assign gm_wd1  = wbuf[0];
    assign gm_wd2  = wbuf[1];
    assign gm_wd3  = wbuf[2];
    assign gm_wd4  = wbuf[3];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr       <= '0;
            left       <= '0;
            idx        <= '0;
            for (int i = 0; i < 4; i++) wbuf[i] <= '0;
            cmd_ready  <= 1'b1;
            rd_valid   <= 1'b0;
            wr_ready   <= 1'b0;
            done       <= 1'b0;
            gm_we      <= 1'b0;
            gm_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr       <= cmd_addr;
                        gm_address <= cmd_addr;
                        // left counts groups still to run after the current one
                        left       <= (cmd_groups == 3'd0) ? 3'd0 : cmd_groups - 3'd1;
                        idx        <= 2'd0;
                        cmd_ready  <= 1'b0;
                        if (cmd_write) begin
                            wr_ready <= 1'b1;
                            state    <= WR_COLLECT;
                        end else begin
                            state    <= RD_LATCH;
                        end
                    end
                end
                RD_LATCH: begin
                    wbuf[0]  <= gm_rd1;
                    wbuf[1]  <= gm_rd2;
                    wbuf[2]  <= gm_rd3;
                    wbuf[3]  <= gm_rd4;
                    rd_valid <= 1'b1;
                    state    <= RD_SEND;
                end
                RD_SEND: begin
                    if (rd_hs) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            rd_valid <= 1'b0;
                            if (left != 3'd0) begin
                                left       <= left - 3'd1;
                                addr       <= next_addr;
                                gm_address <= next_addr;
                                state      <= RD_LATCH;
                            end else begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                end
                WR_COLLECT: begin
                    if (wr_hs) begin
                        wbuf[idx] <= wr_data;
                        idx       <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            wr_ready <= 1'b0;
                            gm_we    <= 1'b1;
                            state    <= WR_COMMIT;
                        end
                    end
                end
                WR_COMMIT: begin
                    gm_we <= 1'b0;
                    if (left != 3'd0) begin
                        left       <= left - 3'd1;
                        addr       <= next_addr;
                        gm_address <= next_addr;
                        wr_ready   <= 1'b1;
                        state      <= WR_COLLECT;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GMEM_STREAM_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stat_words <= 16'd0;
        else if (rd_hs || wr_hs)
            stat_words <= stat_words + 16'd1;
    end
`endif

endmodule

// File: tb/tb_gmem_stream_engine.sv
// Bench for gmem_stream_engine: queue-based model of expected stream
// words and memory commits, plus directed literal expectations.
module tb_gmem_stream_engine;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [2:0]    cmd_groups = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          done;
    logic [AW-1:0] gm_address;
    logic          gm_we;
    logic [DW-1:0] gm_wd1, gm_wd2, gm_wd3, gm_wd4;
    logic [DW-1:0] gm_rd1, gm_rd2, gm_rd3, gm_rd4;
`ifdef GMEM_STREAM_STATS_EN
    logic [15:0]   stat_words;
`endif

    always #5 clock = ~clock;

    gmem_stream_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_groups(cmd_groups),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done(done), .gm_address(gm_address), .gm_we(gm_we),
        .gm_wd1(gm_wd1), .gm_wd2(gm_wd2), .gm_wd3(gm_wd3), .gm_wd4(gm_wd4),
        .gm_rd1(gm_rd1), .gm_rd2(gm_rd2), .gm_rd3(gm_rd3), .gm_rd4(gm_rd4)
`ifdef GMEM_STREAM_STATS_EN
        , .stat_words(stat_words)
`endif
    );

    // memory seen by the DUT (written only by the monitor) and the model's copy
    logic [DW-1:0] mem     [16];
    logic [DW-1:0] ref_mem [16];

    assign gm_rd1 = mem[gm_address];
    assign gm_rd2 = mem[4'(gm_address + 4'd1)];
    assign gm_rd3 = mem[4'(gm_address + 4'd2)];
    assign gm_rd4 = mem[4'(gm_address + 4'd3)];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [DW-1:0] exp_rd [$];
    logic [AW-1:0] exp_wa [$];
    logic [63:0]   exp_wd [$];
    logic [DW-1:0] got_q  [$];
    logic [AW-1:0] we_log [$];

    function automatic logic [DW-1:0] init_val(int i);
        case (i)
            4: return 16'h0011;
            5: return 16'h0022;
            6: return 16'h0033;
            7: return 16'h0044;
            default: return 16'hC000 | 16'(i);
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compares outputs against the model every meaningful cycle
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = init_val(i);
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (rd_valid) begin
                    check("rd_expected", exp_rd.size() > 0, 1);
                    if (exp_rd.size() > 0) begin
                        check("rd_data", rd_data, exp_rd[0]);
                        if (rd_ready) begin
                            got_q.push_back(rd_data);
                            void'(exp_rd.pop_front());
                        end
                    end
                end
                if (gm_we) begin
                    check("we_expected", exp_wa.size() > 0, 1);
                    if (exp_wa.size() > 0) begin
                        check("we_addr", gm_address, exp_wa[0]);
                        check("we_data", {gm_wd1, gm_wd2, gm_wd3, gm_wd4}, exp_wd[0]);
                        void'(exp_wa.pop_front());
                        void'(exp_wd.pop_front());
                    end
                    we_log.push_back(gm_address);
                    mem[gm_address]                = gm_wd1;
                    mem[4'(gm_address + 4'd1)]     = gm_wd2;
                    mem[4'(gm_address + 4'd2)]     = gm_wd3;
                    mem[4'(gm_address + 4'd3)]     = gm_wd4;
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic check_reset_vals(string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_gm_we"}, gm_we, 0);
        check({tag, "_gm_address"}, gm_address, 0);
        check({tag, "_gm_wd"}, {gm_wd1, gm_wd2, gm_wd3, gm_wd4}, 0);
        check({tag, "_rd_data"}, rd_data, 0);
`ifdef GMEM_STREAM_STATS_EN
        check({tag, "_stat_words"}, stat_words, 0);
`endif
    endtask

    // called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic issue(bit wr, logic [3:0] a, logic [2:0] g);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = a;
        cmd_groups = g;
        @(posedge clock); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic finish_burst(string tag, int dcyc, int d0);
        check({tag, "_timeout"}, dcyc > 0, 1);
        check({tag, "_cmd_ready_in_done"}, cmd_ready, 0);
        @(posedge clock); #1;
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_cmd_ready_after"}, cmd_ready, 1);
        check({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    task automatic do_read(logic [3:0] a, logic [2:0] g, logic [3:0] pat,
                           output int lat, output int dcyc);
        int ng = (g == 3'd0) ? 1 : int'(g);
        int cyc = 1;
        int k = 0;
        int d0 = done_cnt;
        lat = -1;
        dcyc = -1;
        got_q.delete();
        for (int gi = 0; gi < ng; gi++)
            for (int j = 0; j < 4; j++)
                exp_rd.push_back(ref_mem[4'(int'(a) + 4 * gi + j)]);
        issue(1'b0, a, g);
        check("rd_latch_no_valid", rd_valid, 0);
        while (cyc < 300) begin
            rd_ready = pat[k % 4];
            k++;
            @(posedge clock); #1;
            cyc++;
            if (rd_valid && lat < 0) lat = cyc;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        rd_ready = 1'b0;
        check("rd_words_left", exp_rd.size(), 0);
        finish_burst("rd", dcyc, d0);
    endtask

    task automatic do_write(logic [3:0] a, logic [2:0] g, logic [15:0] base,
                            output int dcyc);
        int ng = (g == 3'd0) ? 1 : int'(g);
        int cyc = 1;
        int i = 0;
        int d0 = done_cnt;
        bit hs;
        dcyc = -1;
        for (int gi = 0; gi < ng; gi++) begin
            logic [15:0] w0 = base + 16'(4 * gi);
            exp_wa.push_back(4'(int'(a) + 4 * gi));
            exp_wd.push_back({w0, w0 + 16'd1, w0 + 16'd2, w0 + 16'd3});
        end
        issue(1'b1, a, g);
        while (cyc < 300) begin
            wr_valid = (i < 4 * ng);
            wr_data  = base + 16'(i);
            hs = wr_valid && wr_ready;
            @(posedge clock); #1;
            cyc++;
            if (hs) i++;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        wr_valid = 1'b0;
        for (int n = 0; n < 4 * ng; n++)
            ref_mem[4'(int'(a) + n)] = base + 16'(n);
        check("wr_commits_left", exp_wa.size(), 0);
        finish_burst("wr", dcyc, d0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, dcyc, d0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

        #12;
        check_reset_vals("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

`ifdef GMEM_STREAM_STATS_EN
        do_read(4'h0, 3'd3, 4'b1111, lat, dcyc);
        do_write(4'h8, 3'd1, 16'h00B0, dcyc);
        check("stat_words_16", stat_words, 16);
`endif

        // single group read, always ready
        do_read(4'h4, 3'd1, 4'b1111, lat, dcyc);
        check("rd_latency", lat, 2);
        check("rd_done_cycle_g1", dcyc, 6);
        check("rd_literal_words", {got_q[0], got_q[1], got_q[2], got_q[3]},
              64'h0011_0022_0033_0044);

        // ready toggling 1,0,0,1
        do_read(4'h4, 3'd1, 4'b1001, lat, dcyc);
        check("rd_stall_count", got_q.size(), 4);
        check("rd_stall_words", {got_q[0], got_q[1], got_q[2], got_q[3]},
              64'h0011_0022_0033_0044);
        check("rd_stall_slower", dcyc > 6, 1);

        // address wrap 0xE + 4 = 0x2
        do_read(4'hE, 3'd2, 4'b1111, lat, dcyc);
        check("rd_done_cycle_g2", dcyc, 11);
        check("rd_wrap_first", got_q[0], 16'hC00E);
        check("rd_wrap_second", {got_q[4], got_q[5], got_q[6], got_q[7]},
              64'hC002_C003_0011_0022);
        check("rd_wrap_addr", gm_address, 4'h2);

        // groups = 0 behaves as one group
        do_read(4'h4, 3'd0, 4'b1111, lat, dcyc);
        check("rd_groups0_cycle", dcyc, 6);

        // two-group write
        we_log.delete();
        do_write(4'h8, 3'd2, 16'h00A0, dcyc);
        check("wr_done_cycle_g2", dcyc, 11);
        check("wr_we_pulses", we_log.size(), 2);
        if (we_log.size() == 2) begin
            check("wr_we_addr0", we_log[0], 4'h8);
            check("wr_we_addr1", we_log[1], 4'hC);
        end
        for (int i = 0; i < 8; i++)
            check("wr_mem", mem[8 + i], 16'h00A0 + 16'(i));

        // reset mid-write after two words
        we_log.delete();
        d0 = done_cnt;
        issue(1'b1, 4'h0, 3'd1);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'hDEA0 + 16'(i);
            @(posedge clock); #1;
        end
        #2;
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("abort_no_we", we_log.size(), 0);
        check("abort_no_done", done_cnt - d0, 0);
        do_read(4'h0, 3'd1, 4'b1111, lat, dcyc);
        check("abort_mem_intact", {got_q[0], got_q[1], got_q[2], got_q[3]},
              64'hC000_C001_C002_C003);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
